// File: rtl/truth_table_checker.sv
// Response checker for 4-input lab circuits: compares one beat per input vector
// against a parameterised truth table and reports pass/fail, error count and first failure.
module truth_table_checker #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 5,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXPECTED = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             VALID,
    output logic             READY,
    input  logic [N_IN-1:0]  IN_VEC,
    input  logic [N_OUT-1:0] F_IN,
    output logic             DONE,
    output logic             PASS,
    output logic             FAIL,
    output logic [N_IN:0]    ERR_COUNT,
    output logic             SEQ_ERR,
    output logic [N_IN-1:0]  FIRST_ERR_IDX,
    output logic [N_OUT-1:0] FIRST_ERR_GOT
);

    localparam int              DEPTH    = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = '1;
    localparam logic [N_IN:0]   ERR_MAX  = (N_IN+1)'(DEPTH);
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    idx_q, idx_d;
    logic [N_IN:0]      err_count_q, err_count_d;
    logic               seq_err_q, seq_err_d;
    logic [N_IN-1:0]    first_err_idx_q, first_err_idx_d;
    logic [N_OUT-1:0]   first_err_got_q, first_err_got_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;

    logic [N_OUT-1:0]   exp_entry;
    logic               mismatch;

    assign exp_entry = EXPECTED[int'(idx_q)*N_OUT +: N_OUT];
    assign mismatch  = (F_IN != exp_entry);

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        err_count_d     = err_count_q;
        seq_err_d       = seq_err_q;
        first_err_idx_d = first_err_idx_q;
        first_err_got_d = first_err_got_q;
        done_d          = done_q;
        pass_d          = pass_q;
        fail_d          = fail_q;

        // START restarts from any state and takes priority over a beat
        if (START) begin
            state_d         = S_RUN;
            idx_d           = '0;
            err_count_d     = '0;
            seq_err_d       = 1'b0;
            first_err_idx_d = '0;
            first_err_got_d = '0;
            done_d          = 1'b0;
            pass_d          = 1'b0;
            fail_d          = 1'b0;
        end else if (state_q == S_RUN && VALID) begin
            if (mismatch) begin
                if (err_count_q == '0) begin
                    first_err_idx_d = idx_q;
                    first_err_got_d = F_IN;
                end
                if (err_count_q != ERR_MAX) begin
                    err_count_d = err_count_q + ERR_ONE;
                end
            end
            if (IN_VEC != idx_q) begin
                seq_err_d = 1'b1;
            end
            idx_d = idx_q + IDX_ONE;
            if (idx_q == LAST_IDX) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                pass_d  = (err_count_d == '0) && !seq_err_d;
                fail_d  = !((err_count_d == '0) && !seq_err_d);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            err_count_q     <= '0;
            seq_err_q       <= 1'b0;
            first_err_idx_q <= '0;
            first_err_got_q <= '0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            fail_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            err_count_q     <= err_count_d;
            seq_err_q       <= seq_err_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_got_q <= first_err_got_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            fail_q          <= fail_d;
        end
    end

    assign READY         = (state_q == S_RUN);
    assign DONE          = done_q;
    assign PASS          = pass_q;
    assign FAIL          = fail_q;
    assign ERR_COUNT     = err_count_q;
    assign SEQ_ERR       = seq_err_q;
    assign FIRST_ERR_IDX = first_err_idx_q;
    assign FIRST_ERR_GOT = first_err_got_q;

endmodule
